// File: rtl/mips_pkg.sv
// Shared constants for the program-counter unit: FSM state encoding and PC step.
package mips_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_TRAP  = 2'd3;

    localparam logic [31:0] PC_INC               = 32'd4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_control_unit_if.sv
// Control inputs and PC status outputs of the program-counter unit.
interface pc_control_unit_if #(
    parameter int unsigned CNT_WIDTH = 16
) ();

    logic                 en;
    logic                 PCSrc;
    logic [15:0]          BranchImm;
    logic                 Jump;
    logic [25:0]          JumpAddr;
    logic                 JumpReg;
    logic [31:0]          RegAddr;
    logic                 Halt;
    logic [31:0]          PC;
    logic [31:0]          PCPlus4;
    logic                 fetch_valid;
    logic                 halted;
    logic                 misaligned;
    logic [CNT_WIDTH-1:0] redirect_count;

    // Decode/control side drives the controls and observes the PC.
    modport master (
        output en, PCSrc, BranchImm, Jump, JumpAddr, JumpReg, RegAddr, Halt,
        input  PC, PCPlus4, fetch_valid, halted, misaligned, redirect_count
    );

    // PC unit side.
    modport slave (
        input  en, PCSrc, BranchImm, Jump, JumpAddr, JumpReg, RegAddr, Halt,
        output PC, PCPlus4, fetch_valid, halted, misaligned, redirect_count
    );

endinterface

// File: rtl/next_pc_mux.sv
// Target generation and priority select: JumpReg > Jump > PCSrc > PC+4.
module next_pc_mux
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        pcsrc,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_addr,
    input  logic        jump_reg,
    input  logic [31:0] reg_addr,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        jr_misaligned
);

    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    // Word offset sign-extended and scaled by 4; all sums wrap modulo 2^32.
    assign br_tgt = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign j_tgt  = {pc_plus4[31:28], jump_addr, 2'b00};

    // JR has top priority, so a misaligned rs always wins the select.
    assign jr_misaligned = jump_reg && (reg_addr[1:0] != 2'b00);

    // Priority select of the next PC; any non-sequential source is a redirect.
    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        if (jump_reg) begin
            next_pc  = reg_addr;
            redirect = 1'b1;
        end else if (jump) begin
            next_pc  = j_tgt;
            redirect = 1'b1;
        end else if (pcsrc) begin
            next_pc  = br_tgt;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/pc_control_unit.sv
// Program-counter unit: PC register, run/stall/halt/trap FSM, redirect counter.
module pc_control_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst,
    pc_control_unit_if.slave  bus
);

    logic [1:0]           state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          pc_plus4;
    logic [31:0]          next_pc;
    logic                 redirect;
    logic                 jr_misaligned;

    assign pc_plus4 = pc_q + PC_INC;

    next_pc_mux u_next_pc_mux (
        .pc_plus4      (pc_plus4),
        .pcsrc         (bus.PCSrc),
        .branch_imm    (bus.BranchImm),
        .jump          (bus.Jump),
        .jump_addr     (bus.JumpAddr),
        .jump_reg      (bus.JumpReg),
        .reg_addr      (bus.RegAddr),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .jr_misaligned (jr_misaligned)
    );

    // Next-state: STALL resumes exactly like RUN; HALT and TRAP are sticky until reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN, ST_STALL: begin
                if (!bus.en) begin
                    state_d = ST_STALL;
                end else if (bus.Halt) begin
                    state_d = ST_HALT;
                end else if (jr_misaligned) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_RUN;
                    pc_d    = next_pc;
                    if (redirect && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_HALT, ST_TRAP: begin
            end
            default: begin
            end
        endcase
    end

    // State, PC and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PC             = pc_q;
    assign bus.PCPlus4        = pc_plus4;
    assign bus.fetch_valid    = (state_q == ST_RUN);
    assign bus.halted         = (state_q == ST_HALT);
    assign bus.misaligned     = (state_q == ST_TRAP);
    assign bus.redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Scoreboard bench for pc_control_unit: expected status pushed per stimulus, popped per edge.
module tb_pc_control_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_control_unit_if #(.CNT_WIDTH(16)) u ();
    pc_control_unit_if #(.CNT_WIDTH(2))  u2 ();

    pc_control_unit #(.RESET_VECTOR(32'h0), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u)
    );

    pc_control_unit #(.RESET_VECTOR(32'h0), .CNT_WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (u2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        halt;
        logic        jr;
        logic [31:0] raddr;
        logic        jump;
        logic [25:0] jaddr;
        logic        pcsrc;
        logic [15:0] imm;
    } stim_t;

    // Expected {PC, fetch_valid, halted, misaligned, redirect_count}.
    logic [50:0] sb[$];
    logic [36:0] sb2[$];

    function automatic stim_t mk(logic r, logic e, logic h, logic jr, logic [31:0] ra,
                                 logic j, logic [25:0] ja, logic b, logic [15:0] im);
        stim_t s;
        s.rst = r; s.en = e; s.halt = h; s.jr = jr; s.raddr = ra;
        s.jump = j; s.jaddr = ja; s.pcsrc = b; s.imm = im;
        return s;
    endfunction

    function automatic logic [50:0] ex(logic [31:0] pc, logic fv, logic h, logic m,
                                       logic [15:0] c);
        return {pc, fv, h, m, c};
    endfunction

    function automatic logic [50:0] obs();
        return {u.PC, u.fetch_valid, u.halted, u.misaligned, u.redirect_count};
    endfunction

    task automatic apply(stim_t s);
        rst         = s.rst;
        u.en        = s.en;
        u.Halt      = s.halt;
        u.JumpReg   = s.jr;
        u.RegAddr   = s.raddr;
        u.Jump      = s.jump;
        u.JumpAddr  = s.jaddr;
        u.PCSrc     = s.pcsrc;
        u.BranchImm = s.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$]; logic [50:0] xp[$]; logic [50:0] e; logic [50:0] o;
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(32'h0, 1, 0, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(32'h4, 1, 0, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(32'h8, 1, 0, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(32'hC, 1, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            tick();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got pc=%h fv/h/m=%b cnt=%0d, want pc=%h fv/h/m=%b cnt=%0d",
                         i, o[50:19], o[18:16], o[15:0], e[50:19], e[18:16], e[15:0]);
            end
        end
        checks++;
        if (u.PCPlus4 !== 32'h10) begin
            errors++;
            $display("FAIL pcplus4: got %h want 00000010", u.PCPlus4);
        end
    endtask

    task automatic test_branch();
        stim_t st[$]; logic [50:0] xp[$]; logic [50:0] e; logic [50:0] o;
        st.push_back(mk(0, 1, 0, 1, 32'h40, 0, 0, 0, 0));     xp.push_back(ex(32'h40, 1, 0, 0, 1));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 16'hFFFE));   xp.push_back(ex(32'h3C, 1, 0, 0, 2));
        st.push_back(mk(0, 1, 0, 1, 32'h40, 0, 0, 0, 0));     xp.push_back(ex(32'h40, 1, 0, 0, 3));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 16'h0003));   xp.push_back(ex(32'h50, 1, 0, 0, 4));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            tick();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch[%0d]: got pc=%h fv/h/m=%b cnt=%0d, want pc=%h fv/h/m=%b cnt=%0d",
                         i, o[50:19], o[18:16], o[15:0], e[50:19], e[18:16], e[15:0]);
            end
        end
    endtask

    task automatic test_jump();
        stim_t st[$]; logic [50:0] xp[$]; logic [50:0] e; logic [50:0] o;
        st.push_back(mk(0, 1, 0, 1, 32'h1000_0010, 0, 0, 0, 0));
        xp.push_back(ex(32'h1000_0010, 1, 0, 0, 5));
        st.push_back(mk(0, 1, 0, 0, 0, 1, 26'h0000100, 0, 0));
        xp.push_back(ex(32'h1000_0400, 1, 0, 0, 6));
        st.push_back(mk(0, 1, 0, 1, 32'h1000_0010, 0, 0, 0, 0));
        xp.push_back(ex(32'h1000_0010, 1, 0, 0, 7));
        // All three redirects: JR wins and the counter steps once.
        st.push_back(mk(0, 1, 0, 1, 32'h200, 1, 26'h0000100, 1, 16'h0003));
        xp.push_back(ex(32'h200, 1, 0, 0, 8));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            tick();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jump[%0d]: got pc=%h fv/h/m=%b cnt=%0d, want pc=%h fv/h/m=%b cnt=%0d",
                         i, o[50:19], o[18:16], o[15:0], e[50:19], e[18:16], e[15:0]);
            end
        end
    endtask

    task automatic test_stall();
        stim_t st[$]; logic [50:0] xp[$]; logic [50:0] e; logic [50:0] o;
        st.push_back(mk(0, 1, 0, 1, 32'h20, 0, 0, 0, 0));   xp.push_back(ex(32'h20, 1, 0, 0, 9));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h1));    xp.push_back(ex(32'h20, 0, 0, 0, 9));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h1));    xp.push_back(ex(32'h20, 0, 0, 0, 9));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 16'h1));    xp.push_back(ex(32'h28, 1, 0, 0, 10));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            tick();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall[%0d]: got pc=%h fv/h/m=%b cnt=%0d, want pc=%h fv/h/m=%b cnt=%0d",
                         i, o[50:19], o[18:16], o[15:0], e[50:19], e[18:16], e[15:0]);
            end
        end
    endtask

    task automatic test_trap();
        stim_t st[$]; logic [50:0] xp[$]; logic [50:0] e; logic [50:0] o;
        st.push_back(mk(0, 1, 0, 1, 32'h102, 0, 0, 0, 0));       xp.push_back(ex(32'h28, 0, 0, 1, 10));
        st.push_back(mk(0, 1, 0, 1, 32'h100, 0, 0, 0, 0));       xp.push_back(ex(32'h28, 0, 0, 1, 10));
        st.push_back(mk(0, 1, 0, 0, 0, 1, 26'h100, 1, 16'h4));   xp.push_back(ex(32'h28, 0, 0, 1, 10));
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));             xp.push_back(ex(32'h28, 0, 0, 1, 10));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));             xp.push_back(ex(32'h28, 0, 0, 1, 10));
        st.push_back(mk(1, 1, 0, 1, 32'h103, 1, 26'h5, 1, 16'h7)); xp.push_back(ex(32'h0, 1, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            tick();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL trap[%0d]: got pc=%h fv/h/m=%b cnt=%0d, want pc=%h fv/h/m=%b cnt=%0d",
                         i, o[50:19], o[18:16], o[15:0], e[50:19], e[18:16], e[15:0]);
            end
        end
    endtask

    task automatic test_halt();
        stim_t st[$]; logic [50:0] xp[$]; logic [50:0] e; logic [50:0] o;
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));             xp.push_back(ex(32'h4, 1, 0, 0, 0));
        st.push_back(mk(0, 1, 1, 0, 0, 1, 26'h100, 0, 0));       xp.push_back(ex(32'h4, 0, 1, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 0, 1, 26'h100, 0, 0));       xp.push_back(ex(32'h4, 0, 1, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 16'h5));         xp.push_back(ex(32'h4, 0, 1, 0, 0));
        st.push_back(mk(0, 1, 0, 1, 32'h8, 0, 0, 0, 0));         xp.push_back(ex(32'h4, 0, 1, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));             xp.push_back(ex(32'h4, 0, 1, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));             xp.push_back(ex(32'h4, 0, 1, 0, 0));
        st.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));             xp.push_back(ex(32'h0, 1, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            tick();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL halt[%0d]: got pc=%h fv/h/m=%b cnt=%0d, want pc=%h fv/h/m=%b cnt=%0d",
                         i, o[50:19], o[18:16], o[15:0], e[50:19], e[18:16], e[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$]; logic [50:0] xp[$]; logic [50:0] e; logic [50:0] o;
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 16'h0010));       xp.push_back(ex(32'h44, 1, 0, 0, 1));
        st.push_back(mk(0, 1, 0, 0, 0, 1, 26'h20, 0, 0));         xp.push_back(ex(32'h80, 1, 0, 0, 2));
        st.push_back(mk(0, 1, 0, 1, 32'h1000, 0, 0, 0, 0));       xp.push_back(ex(32'h1000, 1, 0, 0, 3));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 16'hFFFF));       xp.push_back(ex(32'h1000, 1, 0, 0, 4));
        st.push_back(mk(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0));  xp.push_back(ex(32'hFFFF_FFFC, 1, 0, 0, 5));
        // Sequential fetch wraps silently past the top of the address space.
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));              xp.push_back(ex(32'h0, 1, 0, 0, 5));
        // Halt beats a misaligned JR.
        st.push_back(mk(0, 1, 1, 1, 32'h3, 0, 0, 0, 0));          xp.push_back(ex(32'h0, 0, 1, 0, 5));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            tick();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: got pc=%h fv/h/m=%b cnt=%0d, want pc=%h fv/h/m=%b cnt=%0d",
                         i, o[50:19], o[18:16], o[15:0], e[50:19], e[18:16], e[15:0]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [36:0] e;
        logic [36:0] o;
        logic [1:0]  c;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        u2.en = 1'b0;
        sb2.push_back({32'h0, 3'b100, 2'd0});
        tick();
        rst = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                u2.en = 1'b1; u2.PCSrc = 1'b1; u2.BranchImm = 16'h0;
                c = (k >= 3) ? 2'd3 : 2'(k);
                sb2.push_back({32'(4 * k), 3'b100, c});
                tick();
            end
            e = sb2.pop_front();
            o = {u2.PC, u2.fetch_valid, u2.halted, u2.misaligned, u2.redirect_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sat[%0d]: got pc=%h fv/h/m=%b cnt=%0d, want pc=%h fv/h/m=%b cnt=%0d",
                         k, o[36:5], o[4:2], o[1:0], e[36:5], e[4:2], e[1:0]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        u2.en = 1'b0; u2.PCSrc = 1'b0; u2.BranchImm = '0; u2.Jump = 1'b0;
        u2.JumpAddr = '0; u2.JumpReg = 1'b0; u2.RegAddr = '0; u2.Halt = 1'b0;
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_trap();
        test_halt();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_control_unit.md
Name: pc_control_unit

Overview:
- Consumer end of the PCSrc signal: the sequential program-counter unit of the single-cycle MIPS core.
- Holds the PC register and forms PC+4, branch, jump and jump-register targets.
- Selects the next PC from PCSrc (the Branch & Zero gate output) and the jump controls.
- Adds stall, halt and misaligned-target trap handling, plus a saturating redirect counter for debug.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
CNT_WIDTH, 16, width of the redirect counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  1 = advance PC this cycle; 0 = stall (hold PC)
PCSrc  input  1  branch taken (Branch & Zero)
BranchImm  input  16  raw I-type immediate (word offset)
Jump  input  1  J/JAL redirect
JumpAddr  input  26  J-type target field
JumpReg  input  1  JR redirect
RegAddr  input  32  rs value for JR
Halt  input  1  halt request from decode
PC  output  32  current PC (registered)
PCPlus4  output  32  PC + 4 (combinational from PC)
fetch_valid  output  1  instruction at PC is to be executed
halted  output  1  unit is in HALT
misaligned  output  1  unit is in TRAP
redirect_count  output  CNT_WIDTH  taken redirects since reset, saturating

Behaviour:
- Reset (rst=1 at a clock edge):
  - PC=RESET_VECTOR, state=RUN, redirect_count=0.
  - fetch_valid=1, halted=0, misaligned=0 from the next cycle.
  - Reset overrides every input and every state, including mid-stall, HALT and TRAP.
- States: RUN, STALL, HALT, TRAP, encoded in 2 bits.
- Target arithmetic, all modulo 2^32 (wrap-around is silent):
  - PCPlus4 = PC + 4.
  - br_tgt = PCPlus4 + ({{14{BranchImm[15]}}, BranchImm, 2'b00}).
  - j_tgt = {PCPlus4[31:28], JumpAddr, 2'b00}.
  - jr_tgt = RegAddr.
- Next-PC priority when advancing: JumpReg > Jump > PCSrc > PCPlus4. Simultaneous redirects resolve by this priority and count once.
- RUN:
  - en=0: go to STALL, PC held, redirect inputs ignored.
  - en=1, Halt=1: go to HALT, PC held. Halt beats all redirects.
  - en=1, JumpReg=1, RegAddr[1:0]!=0: go to TRAP, PC held, counter unchanged.
  - Otherwise en=1: PC <= selected next PC.
  - redirect_count increments (saturating at all-ones) when the selected source is not PCPlus4.
- STALL: PC held; on en=1, evaluate exactly as RUN in that same cycle (no bubble).
- HALT: PC held; only rst exits.
- TRAP: PC held at the faulting JR's address; only rst exits.
- fetch_valid: 1 in RUN, 0 in STALL, HALT and TRAP.
- halted: 1 only in HALT. misaligned: 1 only in TRAP.
- Latency: one clock from control inputs to the new PC. PCPlus4 follows PC combinationally.
- Branch and jump targets are always word-aligned, so only JR can trap.

Decomposition:
- Shared package (mips_pkg): state encoding constants ST_RUN, ST_STALL, ST_HALT, ST_TRAP; PC_INC = 4; RESET_VECTOR default.
- Sub-module next_pc_mux: combinational target generation and priority select. Outputs next_pc, redirect and jr_misaligned.
- The top level holds the state register, PC register and counter.

Test Plan:
1. Reset then 3 cycles with en=1 and no controls -> PC 0x0, 0x4, 0x8, 0xC; fetch_valid=1; redirect_count=0.
2. PC=0x40, PCSrc=1, BranchImm=16'hFFFE -> next PC=0x3C, count=1. With BranchImm=16'h0003 -> 0x50.
3. PC=0x1000_0010 with JumpReg=1, Jump=1, PCSrc=1 all asserted, RegAddr=0x200 -> PC=0x200, count +1 only. Jump alone with JumpAddr=26'h0000100 -> 0x1000_0400.
4. Hold en=0 for 2 cycles at PC=0x20 with PCSrc=1 -> PC stays 0x20, fetch_valid=0. Release en with PCSrc=1, BranchImm=1 -> PC=0x28 the next edge.
5. JumpReg=1, RegAddr=0x102 -> TRAP: misaligned=1, PC held, fetch_valid=0. Further controls ignored; rst=1 -> PC=0x0, state RUN.
6. Halt=1 with Jump=1 -> halted=1, PC unchanged for 5 cycles. Separately, preload the counter near saturation with CNT_WIDTH=2 and apply 5 taken branches -> redirect_count stays 3.
